// File: rtl/morse_digit_keyer.sv
`default_nettype none
// ============================================================================
//  Module   : morse_digit_keyer
//  Purpose  : Sends one decimal digit (0-9) as its five-element International
//             Morse pattern. Times marks (dot = 1 unit, dash = 3 units), the
//             1-unit spaces between elements and a 3-unit trailing gap.
//             Produces a keying level and a gated square-wave tone.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start, digit    - request strobe and digit, taken when ready
//             abort           - cancel a transmission in progress
//             ready, busy     - idle / transmitting
//             key_on, beep    - keying level and tone while keyed
//             elem_idx        - current element 0..4 (0 when idle)
//             done, err       - completion pulse / bad-digit pulse
//  Revision : 1.0 - initial release
// ============================================================================
module morse_digit_keyer #(
    parameter int UNIT_TICKS = 200,
    parameter int TONE_HALF  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] digit,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       key_on,
    output logic       beep,
    output logic [2:0] elem_idx,
    output logic       done,
    output logic       err
);

    localparam int C_TW = $clog2(3 * UNIT_TICKS + 1);
    localparam int C_NW = $clog2(TONE_HALF + 1);

    // Counters load "duration - 1" and the state ends when they reach 0.
    localparam logic [C_TW-1:0] C_DOT_LOAD  = C_TW'(UNIT_TICKS - 1);
    localparam logic [C_TW-1:0] C_DASH_LOAD = C_TW'(3 * UNIT_TICKS - 1);
    localparam logic [C_TW-1:0] C_TW_ONE    = C_TW'(1);
    localparam logic [C_NW-1:0] C_TONE_LAST = C_NW'(TONE_HALF - 1);
    localparam logic [C_NW-1:0] C_NW_ONE    = C_NW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_TAIL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [C_TW-1:0] tcnt_q,  tcnt_d;
    logic [C_NW-1:0] tone_q,  tone_d;
    logic            beep_q,  beep_d;
    logic [2:0]      elem_q,  elem_d;
    // Bit 0 always describes the current element (1 = dash); shifted right
    // as each element completes.
    logic [4:0]      mask_q,  mask_d;
    logic            done_q,  done_d;
    logic            err_q,   err_d;
    logic [4:0]      new_mask;

    // Dash mask for a digit, bit e = element e.
    function automatic logic [4:0] dash_mask(input logic [3:0] d);
        logic [4:0] m;
        int         dv;
        m  = '0;
        dv = int'(d);
        for (int e = 0; e < 5; e++) begin
            if (dv == 0)      m[e] = 1'b1;
            else if (dv <= 5) m[e] = (e >= dv);
            else              m[e] = (e < dv - 5);
        end
        return m;
    endfunction

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        elem_d   = elem_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        new_mask = dash_mask(digit);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (digit <= 4'd9) begin
                        mask_d  = new_mask;
                        elem_d  = 3'd0;
                        state_d = ST_MARK;
                        tcnt_d  = new_mask[0] ? C_DASH_LOAD : C_DOT_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (tcnt_q == '0) begin
                    if (elem_q < 3'd4) begin
                        state_d = ST_SPACE;
                        tcnt_d  = C_DOT_LOAD;
                    end else begin
                        state_d = ST_TAIL;
                        tcnt_d  = C_DASH_LOAD;
                    end
                end else begin
                    tcnt_d = tcnt_q - C_TW_ONE;
                end
            end
            ST_SPACE: begin
                if (tcnt_q == '0) begin
                    state_d = ST_MARK;
                    elem_d  = elem_q + 3'd1;
                    mask_d  = mask_q >> 1;
                    tcnt_d  = mask_q[1] ? C_DASH_LOAD : C_DOT_LOAD;
                end else begin
                    tcnt_d = tcnt_q - C_TW_ONE;
                end
            end
            ST_TAIL: begin
                if (tcnt_q == '0) begin
                    state_d = ST_IDLE;
                    elem_d  = 3'd0;
                    done_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - C_TW_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
                elem_d  = 3'd0;
            end
        endcase

        // Abort only affects an active transmission; in IDLE a simultaneous
        // start is still honoured by the case above.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
            elem_d  = 3'd0;
            done_d  = 1'b0;
        end
    end

    // Tone runs only across consecutive MARK cycles, so every mark begins
    // with beep low and anything else forces it low.
    always_comb begin
        tone_d = '0;
        beep_d = 1'b0;
        if ((state_q == ST_MARK) && (state_d == ST_MARK)) begin
            if (tone_q == C_TONE_LAST) begin
                tone_d = '0;
                beep_d = ~beep_q;
            end else begin
                tone_d = tone_q + C_NW_ONE;
                beep_d = beep_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            tone_q  <= '0;
            beep_q  <= 1'b0;
            elem_q  <= 3'd0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            tone_q  <= tone_d;
            beep_q  <= beep_d;
            elem_q  <= elem_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign busy     = ~ready;
    assign key_on   = (state_q == ST_MARK);
    assign beep     = beep_q;
    assign elem_idx = elem_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire
